ula_ctrl: RTL and testbench

- Instruction sequencer for the 16-bit signed ALU datapath: accepts one instruction per valid/ready handshake and owns an 8 x 16 register file.
- Reads operands, drives the ALU's A/B/param inputs, captures the ALU result and writes it back.
- Also handles LOAD, CLEAR and DISPLAY without using the ALU.
- Sits between the instruction source (switch/FSM front-end) and the ALU plus display logic.

---
 rtl/ula_pkg.sv | 23 ++
 rtl/regfile_8x16.sv | 27 ++
 rtl/ula_ctrl.sv | 114 +++++++++++
 tb/tb_ula_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared widths, opcodes, instruction fields, FSM states and sign extension
package ula_pkg;
  localparam int DATA_W = 16;
  localparam int NREGS = 8;
  localparam int IMM_W = 7;
  localparam int AW = 3;
  localparam int OP_LSB = 13;
  localparam int RD_LSB = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_CLR, S_DISP} state_t;
  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: two async read ports, one sync write port, sync clear-all and single-entry clear
module regfile_8x16 import ula_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              clr,
  input  logic [AW-1:0]     clr_addr
);
  logic [DATA_W-1:0] mem_q [NREGS];
  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (clr) begin
      mem_q[clr_addr] <= '0;
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end
endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: instruction sequencer driving an external ALU and owning an 8x16 register file
module ula_ctrl import ula_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_param,
  input  logic [DATA_W-1:0] alu_s,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid
);
  state_t state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d, disp_value_q, disp_value_d;
  logic [2:0] alu_param_q, alu_param_d, cnt_q, cnt_d;
  logic done_q, done_d, disp_valid_q, disp_valid_d;
  logic [2:0] op, rd, rs1, rs2, in_op;
  logic [IMM_W-1:0] imm;
  logic rtype;
  logic [AW-1:0] ra1;
  logic [DATA_W-1:0] rd1, rd2;
  assign op = instr_q[OP_LSB +: 3];
  assign rd = instr_q[RD_LSB +: 3];
  assign rs1 = instr_q[RS1_LSB +: 3];
  assign rs2 = instr_q[RS2_LSB +: 3];
  assign imm = instr_q[IMM_W-1:0];
  assign in_op = instr[OP_LSB +: 3];
  assign rtype = op == OP_ADD || op == OP_SUB || op == OP_MUL;
  assign ra1 = state_q == S_IDLE ? instr[RD_LSB +: 3] : rs1;
  regfile_8x16 u_rf (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(rs2), .rd1(rd1), .rd2(rd2),
    .we(state_q == S_WB), .wa(rd), .wd(res_q),
    .clr(state_q == S_CLR), .clr_addr(cnt_q)
  );
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_param_d = alu_param_q;
    res_d = res_q;
    cnt_d = cnt_q;
    disp_value_d = disp_value_q;
    done_d = 1'b0;
    disp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        instr_d = instr;
        cnt_d = '0;
        state_d = in_op == OP_CLEAR ? S_CLR : in_op == OP_DISPLAY ? S_DISP : S_READ;
        if (in_op == OP_DISPLAY) begin
          disp_value_d = rd1;
          disp_valid_d = 1'b1;
          done_d = 1'b1;
        end
      end
      S_READ: begin
        alu_a_d = rd1;
        alu_b_d = rtype ? rd2 : sext(imm);
        alu_param_d = op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = op == OP_LOAD ? sext(imm) : alu_s;
        done_d = 1'b1;
        state_d = S_WB;
      end
      S_CLR: begin
        cnt_d = cnt_q + 3'd1;
        done_d = cnt_q == 3'(NREGS-2);
        state_d = cnt_q == 3'(NREGS-1) ? S_IDLE : S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_param_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      disp_value_q <= '0;
      done_q <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_param_q <= alu_param_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      disp_value_q <= disp_value_d;
      done_q <= done_d;
      disp_valid_q <= disp_valid_d;
    end
  end
  assign instr_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_param = alu_param_q;
  assign done = done_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: scoreboard bench for ula_ctrl with a behavioural external ALU
module tb_ula_ctrl;
  import ula_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] instr = '0;
  logic instr_valid = 1'b0;
  logic instr_ready, busy, done, disp_valid;
  logic [15:0] alu_a, alu_b, alu_s, disp_value;
  logic [2:0] alu_param;
  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];
  always #5 clk = ~clk;
  ula_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_param(alu_param), .alu_s(alu_s),
    .busy(busy), .done(done), .disp_value(disp_value), .disp_valid(disp_valid)
  );
  always_comb alu_s = (alu_param == 3'd1 || alu_param == 3'd2) ? alu_a + alu_b :
                      (alu_param == 3'd3 || alu_param == 3'd4) ? alu_a - alu_b :
                      alu_param == 3'd5 ? alu_a * alu_b : 16'h0000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (disp_valid) begin
        if (exp_q.size() == 0) chk("disp_unexpected", 32'(exp_q.size()), 32'd1);
        else chk("disp_value", 32'(disp_value), 32'(exp_q.pop_front()));
      end
    end
  end
  function automatic logic [15:0] r_ins(input logic [2:0] op, rd, rs1, rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction
  function automatic logic [15:0] i_ins(input logic [2:0] op, rd, rs1, input logic [6:0] imm);
    return {op, rd, rs1, imm};
  endfunction
  task automatic run(input logic [15:0] ins, input int exp_busy, input string tag);
    int w, bn, dn, dpos;
    @(negedge clk);
    w = 0;
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    bn = 0;
    dn = 0;
    dpos = 0;
    while (busy && bn < 50) begin
      bn++;
      if (done) begin
        dn++;
        dpos = bn;
      end
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(bn), 32'(exp_busy));
    chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
    chk({tag, "_done_at"}, 32'(dpos), 32'(exp_busy));
  endtask
  task automatic disp(input logic [2:0] r, input logic [15:0] exp);
    exp_q.push_back(exp);
    run(r_ins(OP_DISPLAY, r, 3'd0, 3'd0), 1, "disp");
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_disp_value", 32'(disp_value), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_param", 32'(alu_param), 32'd0);
    run(i_ins(OP_LOAD, 3'd1, 3'd0, 7'h05), 3, "load_r1");
    run(i_ins(OP_LOAD, 3'd2, 3'd0, 7'h7D), 3, "load_r2");
    run(r_ins(OP_ADD, 3'd3, 3'd1, 3'd2), 3, "add");
    chk("add_alu_a", 32'(alu_a), 32'h0005);
    chk("add_alu_b", 32'(alu_b), 32'hFFFD);
    chk("add_alu_param", 32'(alu_param), 32'd1);
    disp(3'd3, 16'h0002);
    run(i_ins(OP_LOAD, 3'd1, 3'd0, 7'h3F), 3, "load63");
    chk("load_alu_param", 32'(alu_param), 32'd0);
    run(r_ins(OP_MUL, 3'd4, 3'd1, 3'd1), 3, "mul_sq");
    chk("mul_alu_a", 32'(alu_a), 32'h003F);
    chk("mul_alu_b", 32'(alu_b), 32'h003F);
    chk("mul_alu_param", 32'(alu_param), 32'd5);
    disp(3'd4, 16'h0F81);
    run(i_ins(OP_LOAD, 3'd5, 3'd0, 7'h40), 3, "load_m64");
    run(r_ins(OP_MUL, 3'd6, 3'd4, 3'd5), 3, "mul_trunc");
    disp(3'd6, 16'h1FC0);
    for (int i = 0; i < 8; i++) run(i_ins(OP_LOAD, 3'(i), 3'd0, 7'(i + 1)), 3, "load_all");
    disp(3'd0, 16'h0001);
    disp(3'd7, 16'h0008);
    run(i_ins(OP_CLEAR, 3'd0, 3'd0, 7'h00), 8, "clear");
    for (int i = 0; i < 8; i++) disp(3'(i), 16'h0000);
    run(i_ins(OP_ADDI, 3'd1, 3'd1, 7'h7F), 3, "addi");
    chk("addi_alu_b", 32'(alu_b), 32'hFFFF);
    chk("addi_alu_param", 32'(alu_param), 32'd2);
    disp(3'd1, 16'hFFFF);
    run(i_ins(OP_SUBI, 3'd1, 3'd1, 7'h40), 3, "subi");
    disp(3'd1, 16'h003F);
    run(i_ins(OP_LOAD, 3'd2, 3'd0, 7'h0A), 3, "load_r2_10");
    d0 = done_cnt;
    @(negedge clk);
    instr = r_ins(OP_ADD, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(16'h0049);
    instr = r_ins(OP_DISPLAY, 3'd3, 3'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready_busy", 32'(instr_ready), 32'd0);
      @(negedge clk);
    end
    chk("hold_ready_idle", 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("hold_dones", 32'(done_cnt - d0), 32'd2);
    d0 = done_cnt;
    @(negedge clk);
    instr = r_ins(OP_ADD, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    disp(3'd3, 16'h0000);
    disp(3'd1, 16'h0000);
    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
